ama_riscv_mmio_perf: RTL and testbench

Memory-mapped responder for the core's data port: owns the `tohost` register, the 64-bit cycle and retired-instruction counters, and the counter-reset control. It sits beside the DMEM on the core's load/store path and decodes a 256-byte window. It serves the software side of what the testbench observes: program writes to `tohost` and reads of the performance counters.

---
 rtl/ama_riscv_mmio_perf.sv | 135 +++++++++++++
 tb/tb_ama_riscv_mmio_perf.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ama_riscv_mmio_perf.sv
// MMIO responder on the core data port: tohost, 64-bit cycle/instret counters
// with hi-word shadows, and a counter-clear control register.
module ama_riscv_mmio_perf #(
    parameter logic [31:0] BASE_ADDR = 32'h0001_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_wr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    input  logic        inst_retired,
    output logic [31:0] csr_tohost,
    output logic        mmio_reset_cnt
);

    localparam logic [7:0] OFF_TOHOST  = 8'h00;
    localparam logic [7:0] OFF_CYC_LO  = 8'h04;
    localparam logic [7:0] OFF_CYC_HI  = 8'h08;
    localparam logic [7:0] OFF_IR_LO   = 8'h0C;
    localparam logic [7:0] OFF_IR_HI   = 8'h10;
    localparam logic [7:0] OFF_CTRL    = 8'h14;

    logic [31:0] tohost_q, tohost_d;
    logic [63:0] cycle_q, cycle_d;
    logic [63:0] instret_q, instret_d;
    logic [31:0] cycle_hi_shadow_q, cycle_hi_shadow_d;
    logic [31:0] instret_hi_shadow_q, instret_hi_shadow_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_err_q, rsp_err_d;
    logic        reset_cnt_q, reset_cnt_d;

    logic [7:0]  off;
    logic        in_win, is_tohost, is_cyc_lo, is_cyc_hi, is_ir_lo, is_ir_hi;
    logic        is_ctrl, is_ro, req_err, acc, ok_rd, ok_wr, clear;
    logic [31:0] rdata;

    // Address decode and acceptance.
    always_comb begin
        off       = req_addr[7:0];
        in_win    = (req_addr[31:8] == BASE_ADDR[31:8]);
        is_tohost = (off == OFF_TOHOST);
        is_cyc_lo = (off == OFF_CYC_LO);
        is_cyc_hi = (off == OFF_CYC_HI);
        is_ir_lo  = (off == OFF_IR_LO);
        is_ir_hi  = (off == OFF_IR_HI);
        is_ctrl   = (off == OFF_CTRL);
        is_ro     = is_cyc_lo || is_cyc_hi || is_ir_lo || is_ir_hi;
        req_err   = !in_win || (req_addr[1:0] != 2'b00) ||
                    !(is_tohost || is_ro || is_ctrl) || (req_wr && is_ro);
        req_ready = !rst && (!rsp_valid_q || rsp_ready);
        acc       = req_valid && req_ready;
        ok_rd     = acc && !req_wr && !req_err;
        ok_wr     = acc && req_wr && !req_err;
        clear     = ok_wr && is_ctrl && req_wdata[0] && req_wstrb[0];
    end

    // Read mux samples pre-edge values so a lo/hi pair never tears.
    always_comb begin
        rdata = 32'h0;
        if (is_tohost) rdata = tohost_q;
        if (is_cyc_lo) rdata = cycle_q[31:0];
        if (is_cyc_hi) rdata = cycle_hi_shadow_q;
        if (is_ir_lo)  rdata = instret_q[31:0];
        if (is_ir_hi)  rdata = instret_hi_shadow_q;
    end

    always_comb begin
        tohost_d            = tohost_q;
        cycle_hi_shadow_d   = cycle_hi_shadow_q;
        instret_hi_shadow_d = instret_hi_shadow_q;
        rsp_valid_d         = rsp_valid_q;
        rsp_data_d          = rsp_data_q;
        rsp_err_d           = rsp_err_q;
        reset_cnt_d         = clear;

        for (int i = 0; i < 4; i++) begin
            if (ok_wr && is_tohost && req_wstrb[i])
                tohost_d[8*i +: 8] = req_wdata[8*i +: 8];
        end

        if (ok_rd && is_cyc_lo) cycle_hi_shadow_d   = cycle_q[63:32];
        if (ok_rd && is_ir_lo)  instret_hi_shadow_d = instret_q[63:32];

        // Clear wins over the same-edge increment.
        cycle_d   = clear ? 64'h0 : cycle_q + 64'd1;
        instret_d = clear ? 64'h0 : instret_q + {63'h0, inst_retired};

        if (acc) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = req_err;
            rsp_data_d  = ok_rd ? rdata : 32'h0;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tohost_q            <= 32'h0;
            cycle_q             <= 64'h0;
            instret_q           <= 64'h0;
            cycle_hi_shadow_q   <= 32'h0;
            instret_hi_shadow_q <= 32'h0;
            rsp_valid_q         <= 1'b0;
            rsp_data_q          <= 32'h0;
            rsp_err_q           <= 1'b0;
            reset_cnt_q         <= 1'b0;
        end else begin
            tohost_q            <= tohost_d;
            cycle_q             <= cycle_d;
            instret_q           <= instret_d;
            cycle_hi_shadow_q   <= cycle_hi_shadow_d;
            instret_hi_shadow_q <= instret_hi_shadow_d;
            rsp_valid_q         <= rsp_valid_d;
            rsp_data_q          <= rsp_data_d;
            rsp_err_q           <= rsp_err_d;
            reset_cnt_q         <= reset_cnt_d;
        end
    end

    assign rsp_valid      = rsp_valid_q;
    assign rsp_data       = rsp_data_q;
    assign rsp_err        = rsp_err_q;
    assign csr_tohost     = tohost_q;
    assign mmio_reset_cnt = reset_cnt_q;

endmodule

// File: tb/tb_ama_riscv_mmio_perf.sv
// Directed + random bench for ama_riscv_mmio_perf against a cycle-level
// behavioural model of the register map.
module tb_ama_riscv_mmio_perf;

    localparam logic [31:0] BASE = 32'h0001_0000;

    logic        clk = 1'b0;
    logic        rst, req_valid, req_wr, rsp_ready, inst_retired;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        req_ready, rsp_valid, rsp_err, mmio_reset_cnt;
    logic [31:0] rsp_data, csr_tohost;

    always #5 clk = ~clk;

    ama_riscv_mmio_perf #(.BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wr(req_wr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .inst_retired(inst_retired),
        .csr_tohost(csr_tohost), .mmio_reset_cnt(mmio_reset_cnt)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Reference state: architectural values as software would see them.
    logic [63:0] m_cycle, m_instret;
    logic [31:0] m_tohost, m_sh_c, m_sh_i, m_rd;
    logic        m_rv, m_re, m_pulse;
    logic        cur_acc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic addr_err(input logic [31:0] a, input logic wr);
        logic [7:0] o;
        logic known, ro;
        o     = a[7:0];
        ro    = (o == 8'h04) || (o == 8'h08) || (o == 8'h0C) || (o == 8'h10);
        known = ro || (o == 8'h00) || (o == 8'h14);
        return (a[31:8] != BASE[31:8]) || (a[1:0] != 2'b00) || !known || (wr && ro);
    endfunction

    // One clock edge of the model, using the inputs currently driven.
    task automatic model_edge();
        logic        e;
        logic        clr;
        logic [31:0] v;
        if (rst) begin
            m_cycle = 0; m_instret = 0; m_tohost = 0; m_sh_c = 0; m_sh_i = 0;
            m_rd = 0; m_rv = 0; m_re = 0; m_pulse = 0;
            return;
        end
        e   = addr_err(req_addr, req_wr);
        clr = 1'b0;
        if (cur_acc) begin
            v = 32'h0;
            if (!req_wr && !e) begin
                case (req_addr[7:0])
                    8'h00: v = m_tohost;
                    8'h04: begin v = m_cycle[31:0];   m_sh_c = m_cycle[63:32];   end
                    8'h08: v = m_sh_c;
                    8'h0C: begin v = m_instret[31:0]; m_sh_i = m_instret[63:32]; end
                    8'h10: v = m_sh_i;
                    default: v = 32'h0;
                endcase
            end
            if (req_wr && !e && req_addr[7:0] == 8'h00) begin
                for (int i = 0; i < 4; i++)
                    if (req_wstrb[i]) m_tohost[8*i +: 8] = req_wdata[8*i +: 8];
            end
            clr  = req_wr && !e && req_addr[7:0] == 8'h14 && req_wdata[0] && req_wstrb[0];
            m_rv = 1'b1; m_re = e; m_rd = v;
        end else if (rsp_ready) begin
            m_rv = 1'b0;
        end
        m_cycle   = clr ? 64'h0 : m_cycle + 1;
        m_instret = clr ? 64'h0 : m_instret + (inst_retired ? 64'd1 : 64'd0);
        m_pulse   = clr;
    endtask

    task automatic drive(input logic r, input logic v, input logic w, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] ws, input logic rr,
                         input logic ret);
        logic exp_ready;
        @(negedge clk);
        rst = r; req_valid = v; req_wr = w; req_addr = a; req_wdata = wd;
        req_wstrb = ws; rsp_ready = rr; inst_retired = ret;
        #1;
        exp_ready = !r && (!m_rv || rr);
        chk("req_ready", {63'h0, req_ready}, {63'h0, exp_ready});
        cur_acc = v && exp_ready;
    endtask

    task automatic check_out();
        chk("rsp_valid", {63'h0, rsp_valid}, {63'h0, m_rv});
        chk("csr_tohost", {32'h0, csr_tohost}, {32'h0, m_tohost});
        chk("mmio_reset_cnt", {63'h0, mmio_reset_cnt}, {63'h0, m_pulse});
        if (m_rv) begin
            chk("rsp_data", {32'h0, rsp_data}, {32'h0, m_rd});
            chk("rsp_err", {63'h0, rsp_err}, {63'h0, m_re});
        end
    endtask

    task automatic step(input logic r, input logic v, input logic w, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] ws, input logic rr,
                        input logic ret);
        drive(r, v, w, a, wd, ws, rr, ret);
        @(posedge clk);
        model_edge();
        #1;
        check_out();
    endtask

    task automatic idle(input logic ret);
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, ret);
    endtask
    task automatic rd(input logic [31:0] a, input logic ret);
        step(1'b0, 1'b1, 1'b0, a, 32'h0, 4'h0, 1'b1, ret);
    endtask
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic ret);
        step(1'b0, 1'b1, 1'b1, a, d, s, 1'b1, ret);
    endtask

    initial begin
        logic [31:0] held, a;
        logic [3:0]  pick;
        m_cycle = 0; m_instret = 0; m_tohost = 0; m_sh_c = 0; m_sh_i = 0;
        m_rd = 0; m_rv = 0; m_re = 0; m_pulse = 0; cur_acc = 0;
        rst = 1; req_valid = 0; req_wr = 0; req_addr = 0; req_wdata = 0;
        req_wstrb = 0; rsp_ready = 1; inst_retired = 0;

        // Reset: everything zero, not ready.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0);
        chk("reset_tohost", {32'h0, csr_tohost}, 64'h0);
        chk("reset_req_ready", {63'h0, req_ready}, 64'h0);

        // Read on the 10th post-reset edge sees 9.
        for (int i = 0; i < 9; i++) idle(1'b0);
        rd(BASE + 32'h04, 1'b0);
        chk("cycle_lo_first", {32'h0, rsp_data}, 64'd9);
        rd(BASE + 32'h08, 1'b0);
        chk("cycle_hi_first", {32'h0, rsp_data}, 64'd0);

        // Byte-strobed tohost.
        wr(BASE, 32'h0000_0001, 4'b0001, 1'b0);
        chk("tohost_b0", {32'h0, csr_tohost}, 64'h1);
        wr(BASE, 32'hAABB_CC00, 4'b1100, 1'b0);
        chk("tohost_b23", {32'h0, csr_tohost}, 64'hAABB_0001);
        rd(BASE, 1'b0);
        chk("tohost_rd", {32'h0, rsp_data}, 64'hAABB_0001);

        // Preload cycle near the 32-bit boundary.
        idle(1'b0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0);
        force dut.cycle_q = 64'h0000_0000_FFFF_FFFE;
        @(posedge clk);
        model_edge();
        m_cycle = 64'h0000_0000_FFFF_FFFE;
        #1;
        release dut.cycle_q;
        check_out();
        rd(BASE + 32'h04, 1'b0);
        chk("wrap_lo", {32'h0, rsp_data}, 64'hFFFF_FFFE);
        rd(BASE + 32'h08, 1'b0);
        chk("wrap_hi", {32'h0, rsp_data}, 64'h0);
        for (int i = 0; i < 3; i++) idle(1'b0);
        rd(BASE + 32'h04, 1'b0);
        chk("post_wrap_lo", {32'h0, rsp_data}, 64'h3);
        rd(BASE + 32'h08, 1'b0);
        chk("post_wrap_hi", {32'h0, rsp_data}, 64'h1);

        // Clear coincident with the 5th retirement.
        for (int i = 0; i < 4; i++) idle(1'b1);
        wr(BASE + 32'h14, 32'h1, 4'b0001, 1'b1);
        chk("clr_pulse", {63'h0, mmio_reset_cnt}, 64'h1);
        rd(BASE + 32'h0C, 1'b0);
        chk("clr_pulse_gone", {63'h0, mmio_reset_cnt}, 64'h0);
        chk("instret_cleared", {32'h0, rsp_data}, 64'h0);
        rd(BASE + 32'h04, 1'b0);
        chk("cycle_cleared", {32'h0, rsp_data}, 64'h1);

        // Backpressure: response held, not ready, then same-cycle accept.
        rd(BASE, 1'b0);
        held = rsp_data;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, BASE + 32'h04, 32'h0, 4'h0, 1'b0, 1'b0);
            chk("stall_data", {32'h0, rsp_data}, {32'h0, held});
            chk("stall_ready", {63'h0, req_ready}, 64'h0);
        end
        step(1'b0, 1'b1, 1'b0, BASE + 32'h04, 32'h0, 4'h0, 1'b1, 1'b0);
        chk("release_accept", {63'h0, rsp_valid}, 64'h1);

        // Error cases: no side effects.
        rd(BASE + 32'h02, 1'b0);
        chk("err_misalign", {31'h0, rsp_err, rsp_data}, 64'h1_0000_0000);
        rd(BASE + 32'h40, 1'b0);
        chk("err_hole", {31'h0, rsp_err, rsp_data}, 64'h1_0000_0000);
        wr(32'h0, 32'hDEAD_BEEF, 4'hF, 1'b0);
        chk("err_outside", {31'h0, rsp_err, rsp_data}, 64'h1_0000_0000);
        wr(BASE + 32'h04, 32'h0, 4'hF, 1'b0);
        chk("err_ro_write", {31'h0, rsp_err, rsp_data}, 64'h1_0000_0000);
        chk("err_tohost_kept", {32'h0, csr_tohost}, 64'hAABB_0001);
        rd(BASE + 32'h04, 1'b0);

        // Reset mid-transaction drops the pending response.
        step(1'b0, 1'b1, 1'b0, BASE, 32'h0, 4'h0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, BASE, 32'h0, 4'h0, 1'b0, 1'b0);
        chk("rst_drop", {63'h0, rsp_valid}, 64'h0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            pick = 4'($urandom_range(0, 9));
            case (pick)
                4'd7:    a = BASE + 32'h40;
                4'd8:    a = BASE + 32'h02;
                4'd9:    a = 32'h0000_0010;
                default: a = BASE + {26'h0, pick[2:0], 2'b00} % 32'h18;
            endcase
            step(($urandom_range(0, 99) == 0), 1'($urandom), ($urandom_range(0, 3) == 0), a,
                 (a[7:0] == 8'h14) ? {31'h0, ($urandom_range(0, 3) == 0)} : $urandom,
                 4'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
